seg7_time_display: RTL and testbench
====================================

Name: seg7_time_display

Overview:
- Consumes the four BCD time digits from the 24 h clock counter (hours tens/units, minutes tens/units) and drives the Basys3 4-digit common-anode 7-segment display.
- Time-multiplexes the digits and snapshots the inputs once per frame so the display never tears.
- Adds anti-ghosting blank time at each digit switch and a 1 Hz blinking colon on the DP of the hours-units digit.
- Sits between the clock block and the board pins.

Parameters:
- REFRESH_DIV, 100_000: clk cycles per digit slot (1 ms at 100 MHz; 250 Hz frame). Minimum 2·GUARD_CYC+2.
- GUARD_CYC, 4: cycles at the start of each slot with all anodes off.
- BLINK_DIV, 50_000_000: clk cycles per DP phase (0.5 s on, 0.5 s off).
- BLANK_LEADING, 0: if 1, hours-tens is blanked whenever its snapshot value is 0.

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high
- hora_d  in  4  BCD hours tens
- hora_u  in  4  BCD hours units
- min_d  in  4  BCD minutes tens
- min_u  in  4  BCD minutes units
- en  in  1  display enable; 0 blanks the display, counters keep running
- an  out  4  anodes, active-low; an[3] leftmost
- seg  out  7  cathodes, active-low; seg[0]=CA … seg[6]=CG
- dp  out  1  decimal point, active-low

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high. All state changes on posedge clk.
- Reset values:
  - an=4'b1111, seg=7'b1111111, dp=1.
  - Refresh count, slot index and blink count = 0; blink phase = 0 (DP off).
  - Snapshot = 0, so the first frame shows 00:00.
- Refresh counter rc counts 0..REFRESH_DIV-1 and wraps.
  - At rc==REFRESH_DIV-1, slot index idx (2 bits) increments mod 4.
  - Slot mapping: idx0→an[0]/min_u, idx1→an[1]/min_d, idx2→an[2]/hora_u, idx3→an[3]/hora_d.
- Snapshot: at rc==REFRESH_DIV-1 with idx==3, all four inputs load into snapshot registers. The new values are first visible in the idx0 slot. Input changes at any other time are ignored until the next frame.
- Guard: while rc<GUARD_CYC, the registered an=4'b1111 and dp=1; seg may already show the new pattern.
- Outputs are registered, 1-cycle latency from the rc/idx/snapshot state to the pins. Outside the guard window, an has exactly one bit low.
- Decode per slot through bcd_to_seg7:
  - Values 0–9 use the standard patterns.
  - Values 10–15 show a dash, seg=7'b0111111 (CG only).
- Blink: counter bc counts 0..BLINK_DIV-1. At terminal count the phase toggles.
  - dp=0 only when phase==1, idx==2, and not in the guard window.
  - dp=1 in every other case.
- BLANK_LEADING=1 with snapshot hora_d==0: an[3] stays high for the whole idx3 slot. seg content is don't-care.
- en=0: an=4'b1111, seg=7'b1111111, dp=1 (registered, 1 cycle). rc, idx, bc, phase and snapshot continue, so re-enable resumes mid-frame with no glitch reset.
- Reset asserted mid-slot: on the next edge everything returns to the reset values. The snapshot clears to 0.

Decomposition:
- Package seg7_pkg holds:
  - Active-low pattern constants SEG_0..SEG_9: 7'b1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - SEG_DASH=7'b0111111 and SEG_OFF=7'b1111111.
  - typedef logic [1:0] digit_idx_t.
- One sub-module, bcd_to_seg7: combinational 4-bit BCD to 7-bit active-low pattern, with the dash for values >9.
- Top level holds counters, snapshot, muxing and output registers.

Test Plan (REFRESH_DIV=8, GUARD_CYC=2, BLINK_DIV=20):
- Reset check: hold reset 3 cycles → an=1111, seg=1111111, dp=1. First full frame shows seg=SEG_0 on every slot. an sequence per slot is 2 cycles of 1111, then 1110 / 1101 / 1011 / 0111 for 6 cycles each.
- Snapshot: drive 1,2,3,4 (12:34) mid-frame during idx1 → current frame still shows 0. Next frame shows min_u slot SEG_4, min_d SEG_3, hora_u SEG_2, hora_d SEG_1. Changing inputs at idx2 does not alter that frame.
- Invalid BCD: min_u=4'hC → the idx0 slot shows seg=7'b0111111.
- Blink: run 80 cycles → dp=0 only during non-guard idx2 cycles within 20-cycle windows where phase=1, alternating with 20-cycle windows of dp=1.
- Enable and leading-zero blanking:
  - en=0 for 30 cycles → an=1111, dp=1 throughout. After re-enable, the idx value matches a free-running model.
  - BLANK_LEADING=1 with input 0,9,5,9 (09:59) → an[3] is never low; the other slots show 9, 5, 9.
- Mid-slot reset: assert reset at rc=5, idx=2 → next cycle an=1111, seg=1111111, dp=1. After release, the first slot is idx0 showing SEG_0.

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared constants and types for the 4-digit 7-segment
//                time display. Segment patterns are active-low, with
//                bit 0 = CA through bit 6 = CG.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [3:0] AN_OFF   = 4'b1111;

    typedef logic [1:0] digit_idx_t;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_time_display_bcd_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_seg7
//  Description : Combinational BCD to active-low 7-segment decoder.
//                Codes 10..15 are shown as a dash (CG lit only).
//  Ports       : bcd  in  [3:0]  BCD digit
//                seg  out [6:0]  active-low pattern, seg[0]=CA .. seg[6]=CG
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule : bcd_to_seg7
`default_nettype wire

// File: rtl/seg7_time_display.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_time_display
//  Description : Time-multiplexed driver for a 4-digit common-anode
//                7-segment display showing HH:MM. Inputs are snapshotted
//                once per frame, each digit slot opens with an all-off
//                guard window against ghosting, and the DP of the
//                hours-units digit blinks as the colon.
//  Ports       : clk     in        system clock
//                reset   in        synchronous, active-high
//                hora_d  in  [3:0] BCD hours tens
//                hora_u  in  [3:0] BCD hours units
//                min_d   in  [3:0] BCD minutes tens
//                min_u   in  [3:0] BCD minutes units
//                en      in        display enable (counters keep running)
//                an      out [3:0] anodes, active-low, an[3] leftmost
//                seg     out [6:0] cathodes, active-low, seg[0]=CA
//                dp      out       decimal point, active-low
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_time_display
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV   = 100_000,
    parameter int GUARD_CYC     = 4,
    parameter int BLINK_DIV     = 50_000_000,
    parameter int BLANK_LEADING = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] hora_d,
    input  logic [3:0] hora_u,
    input  logic [3:0] min_d,
    input  logic [3:0] min_u,
    input  logic       en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int RC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BC_W = (BLINK_DIV > 1)   ? $clog2(BLINK_DIV)   : 1;

    localparam logic [RC_W-1:0] c_rc_last = RC_W'(REFRESH_DIV - 1);
    localparam logic [RC_W-1:0] c_guard   = RC_W'(GUARD_CYC);
    localparam logic [BC_W-1:0] c_bc_last = BC_W'(BLINK_DIV - 1);

    logic [RC_W-1:0] r_rc;
    logic [BC_W-1:0] r_bc;
    digit_idx_t      r_idx;
    logic            r_phase;
    logic [3:0]      r_hd, r_hu, r_md, r_mu;
    logic [3:0]      r_an;
    logic [6:0]      r_seg;
    logic            r_dp;

    logic [3:0]      w_digit;
    logic [6:0]      w_pattern;
    logic            w_guard;
    logic            w_blank_lead;
    logic [3:0]      w_an_nxt;
    logic [6:0]      w_seg_nxt;
    logic            w_dp_nxt;

    // Digit shown in the current slot comes from the frame snapshot only,
    // so a mid-frame input change can never produce a torn display.
    always_comb begin
        w_digit = r_mu;
        case (r_idx)
            2'd0:    w_digit = r_mu;
            2'd1:    w_digit = r_md;
            2'd2:    w_digit = r_hu;
            default: w_digit = r_hd;
        endcase
    end

    bcd_to_seg7 u_dec (
        .bcd (w_digit),
        .seg (w_pattern)
    );

    assign w_guard      = (r_rc < c_guard);
    assign w_blank_lead = (BLANK_LEADING != 0) && (r_idx == 2'd3) && (r_hd == 4'd0);

    always_comb begin
        w_an_nxt  = AN_OFF;
        w_seg_nxt = SEG_OFF;
        w_dp_nxt  = 1'b1;
        if (en) begin
            w_seg_nxt = w_pattern;
            if (!w_guard && !w_blank_lead) begin
                w_an_nxt = ~(4'b0001 << r_idx);
            end
            // Colon: DP of hours-units digit, lit in the "on" blink phase.
            if (r_phase && (r_idx == 2'd2) && !w_guard) begin
                w_dp_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rc    <= '0;
            r_idx   <= '0;
            r_bc    <= '0;
            r_phase <= 1'b0;
            r_hd    <= 4'd0;
            r_hu    <= 4'd0;
            r_md    <= 4'd0;
            r_mu    <= 4'd0;
            r_an    <= AN_OFF;
            r_seg   <= SEG_OFF;
            r_dp    <= 1'b1;
        end else begin
            if (r_rc == c_rc_last) begin
                r_rc  <= '0;
                r_idx <= r_idx + 2'd1;
                // Load at the very end of the last slot so the new values
                // first appear in slot 0 of the next frame.
                if (r_idx == 2'd3) begin
                    r_hd <= hora_d;
                    r_hu <= hora_u;
                    r_md <= min_d;
                    r_mu <= min_u;
                end
            end else begin
                r_rc <= r_rc + 1'b1;
            end

            if (r_bc == c_bc_last) begin
                r_bc    <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_bc <= r_bc + 1'b1;
            end

            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
            r_dp  <= w_dp_nxt;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule : seg7_time_display
`default_nettype wire

// File: tb/tb_seg7_time_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_time_display
//  Description : Self-checking bench for seg7_time_display with
//                REFRESH_DIV=8, GUARD_CYC=2, BLINK_DIV=20. A second
//                instance has leading-zero blanking enabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_time_display;

    logic       clk;
    logic       reset;
    logic [3:0] hora_d, hora_u, min_d, min_u;
    logic       en;
    logic [3:0] an, an_b;
    logic [6:0] seg, seg_b;
    logic       dp, dp_b;

    int checks = 0;
    int errors = 0;

    // Bench model state: st is the DUT state count since reset release,
    // m_* is the expected snapshot.
    int         st = 0;
    logic [3:0] m_hd = 4'd0, m_hu = 4'd0, m_md = 4'd0, m_mu = 4'd0;

    seg7_time_display #(
        .REFRESH_DIV   (8),
        .GUARD_CYC     (2),
        .BLINK_DIV     (20),
        .BLANK_LEADING (0)
    ) u_dut (
        .clk    (clk),
        .reset  (reset),
        .hora_d (hora_d),
        .hora_u (hora_u),
        .min_d  (min_d),
        .min_u  (min_u),
        .en     (en),
        .an     (an),
        .seg    (seg),
        .dp     (dp)
    );

    seg7_time_display #(
        .REFRESH_DIV   (8),
        .GUARD_CYC     (2),
        .BLINK_DIV     (20),
        .BLANK_LEADING (1)
    ) u_dut_blank (
        .clk    (clk),
        .reset  (reset),
        .hora_d (hora_d),
        .hora_u (hora_u),
        .min_d  (min_d),
        .min_u  (min_u),
        .en     (en),
        .an     (an_b),
        .seg    (seg_b),
        .dp     (dp_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (st=%0d)", tag, got, exp, st);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // One clock: predict the registered outputs from the pre-edge state,
    // advance the model, then compare just after the edge.
    task automatic step();
        logic [3:0] e_an, e_an_b, dig;
        logic [6:0] e_seg;
        logic       e_dp;
        int         rc, idx, ph;
        rc  = st % 8;
        idx = (st / 8) % 4;
        ph  = (st / 20) % 2;
        case (idx)
            0:       dig = m_mu;
            1:       dig = m_md;
            2:       dig = m_hu;
            default: dig = m_hd;
        endcase
        if (reset || !en) begin
            e_an   = 4'b1111;
            e_seg  = 7'b1111111;
            e_dp   = 1'b1;
            e_an_b = 4'b1111;
        end else begin
            e_an   = (rc < 2) ? 4'b1111 : ~(4'b0001 << idx);
            e_seg  = seg_of(dig);
            e_dp   = !(ph == 1 && idx == 2 && rc >= 2);
            e_an_b = (idx == 3 && m_hd == 4'd0) ? 4'b1111 : e_an;
        end
        if (reset) begin
            st = 0;
            m_hd = 4'd0; m_hu = 4'd0; m_md = 4'd0; m_mu = 4'd0;
        end else begin
            if (st % 32 == 31) begin
                m_hd = hora_d; m_hu = hora_u; m_md = min_d; m_mu = min_u;
            end
            st++;
        end
        @(posedge clk);
        #1;
        check("an", 32'(an), 32'(e_an));
        check("seg", 32'(seg), 32'(e_seg));
        check("dp", 32'(dp), 32'(e_dp));
        check("an_b", 32'(an_b), 32'(e_an_b));
        check("dp_b", 32'(dp_b), 32'(e_dp));
        if (e_an_b == e_an) check("seg_b", 32'(seg_b), 32'(e_seg));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset  = 1'b1;
        en     = 1'b1;
        hora_d = 4'd0; hora_u = 4'd0; min_d = 4'd0; min_u = 4'd0;

        // Reset held for three cycles
        run(3);
        check("rst_an", 32'(an), 32'h0000000F);
        check("rst_seg", 32'(seg), 32'h0000007F);
        check("rst_dp", 32'(dp), 32'h00000001);
        reset = 1'b0;

        // First frame shows 00:00; load 12:34 during idx1
        run(10);
        hora_d = 4'd1; hora_u = 4'd2; min_d = 4'd3; min_u = 4'd4;
        run(32);
        // Frame 1 now showing 12:34; change inputs during idx2
        run(8);
        hora_d = 4'd0; hora_u = 4'd9; min_d = 4'd5; min_u = 4'hC;
        run(14);
        // Frame 1 idx3 slot (state 56..63): outputs for state 58 onward
        check("frame1_seg_hd", 32'(seg), 32'(7'b1111001));
        // Frame 2 shows dash on min_u; long run covers blink phases
        run(80);
        min_u = 4'd9;
        run(40);

        // Display disabled for 30 cycles, then resume mid-frame
        en = 1'b0;
        run(30);
        en = 1'b1;
        run(40);

        // Reset in the middle of idx2 at rc=5
        for (int k = 0; k < 40 && (st % 32) != 21; k++) step();
        check("reach_rc5_idx2", 32'(st % 32), 32'd21);
        reset = 1'b1;
        step();
        check("midrst_an", 32'(an), 32'h0000000F);
        check("midrst_seg", 32'(seg), 32'h0000007F);
        check("midrst_dp", 32'(dp), 32'h00000001);
        reset = 1'b0;
        run(3);
        check("post_rst_an", 32'(an), 32'(4'b1110));
        check("post_rst_seg", 32'(seg), 32'(7'b1000000));
        run(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_seg7_time_display
`default_nettype wire
